// File: rtl/simon_sequencer.sv
// -----------------------------------------------------------------------------
// simon_sequencer
//   Game-side producer for the Simon Says datapath. Grows a pseudo-random
//   colour sequence one element per round, plays it back to the grid display
//   as a one-hot colour, then checks the player's KEY presses against it.
//
//   Optional build macro: SIMON_TIMEOUT_EN
//     defined   -> the player loses after 300 ticks in USER with no valid press
//     undefined -> USER waits indefinitely (no timeout logic)
//
// Ports:
//   CLOCK_50  in   1  system clock
//   reset     in   1  synchronous, active-high reset
//   start     in   1  level start request (looked at in IDLE, WIN, FAIL)
//   level     in   3  difficulty 1..5 (0 or >5 treated as 1), latched leaving IDLE
//   key_n     in   4  raw active-low keys, asynchronous to CLOCK_50
//   state     out  2  00 idle, 01 playback, 10 user entry, 11 end
//   color     out  4  one-hot colour lit on the display, 0000 = none
//   round     out  5  current sequence length
//   fail      out  1  high while in FAIL
//   win       out  1  high while in WIN
// -----------------------------------------------------------------------------
module simon_sequencer #(
   parameter int          MAX_LEN     = 16,
   parameter int          TICK_CYCLES = 500000,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] level,
   input  logic [3:0] key_n,
   output logic [1:0] state,
   output logic [3:0] color,
   output logic [4:0] round,
   output logic       fail,
   output logic       win
);

   localparam int TW    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int DEPTH = 1 << AW;

   typedef enum logic [2:0] {
      S_IDLE, S_ADD, S_PLAY_OFF, S_PLAY_ON, S_USER, S_FAIL, S_WIN
   } fsm_t;

   fsm_t          fsm_q, fsm_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [5:0]    ph_cnt_q, ph_cnt_d;
   logic [2:0]    lvl_q, lvl_d;
   logic [4:0]    round_q, round_d;
   logic [4:0]    index_q, index_d;
   logic [1:0]    mem_q [DEPTH];
   logic [1:0]    mem_d [DEPTH];
   logic [3:0]    key_s1_q, key_s1_d;
   logic [3:0]    key_s2_q, key_s2_d;
   logic [3:0]    key_prev_q, key_prev_d;
`ifdef SIMON_TIMEOUT_EN
   logic [8:0]    to_cnt_q, to_cnt_d;
`endif

   logic       tick;
   logic [2:0] lvl_eff;
   logic [5:0] on_ticks, off_ticks;
   logic       key_evt;
   logic [1:0] key_code;

   assign tick    = (tick_cnt_q == TW'(TICK_CYCLES - 1));
   assign lvl_eff = ((level == 3'd0) || (level > 3'd5)) ? 3'd1 : level;
   assign on_ticks  = 6'((32'd6 - 32'(lvl_q)) * 32'd10);
   assign off_ticks = 6'((32'd6 - 32'(lvl_q)) * 32'd5);

   // A press is a new falling bit on the synced keys, accepted only while
   // exactly one key is held; chords and bounces across keys are dropped.
   assign key_evt = (|(key_prev_q & ~key_s2_q)) && $onehot(~key_s2_q);

   always_comb begin
      key_code = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (!key_s2_q[k]) key_code = 2'(k);
      end
   end

   // Next-state logic
   always_comb begin
      fsm_d      = fsm_q;
      lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      ph_cnt_d   = ph_cnt_q;
      lvl_d      = lvl_q;
      round_d    = round_q;
      index_d    = index_q;
      mem_d      = mem_q;
      key_s1_d   = key_n;
      key_s2_d   = key_s1_q;
      key_prev_d = key_s2_q;
`ifdef SIMON_TIMEOUT_EN
      to_cnt_d   = to_cnt_q;
`endif

      case (fsm_q)
         S_IDLE: begin
            if (start) begin
               lvl_d   = lvl_eff;
               round_d = '0;
               fsm_d   = S_ADD;
            end
         end
         S_ADD: begin
            mem_d[round_q[AW-1:0]] = lfsr_q[1:0];
            round_d = round_q + 5'd1;
            index_d = '0;
            fsm_d   = S_PLAY_OFF;
         end
         S_PLAY_OFF: begin
            if (tick) begin
               if (ph_cnt_q == off_ticks - 6'd1) begin
                  if (index_q < round_q) begin
                     fsm_d = S_PLAY_ON;
                  end else begin
                     index_d = '0;
                     fsm_d   = S_USER;
                  end
               end else begin
                  ph_cnt_d = ph_cnt_q + 6'd1;
               end
            end
         end
         S_PLAY_ON: begin
            if (tick) begin
               if (ph_cnt_q == on_ticks - 6'd1) begin
                  index_d = index_q + 5'd1;
                  fsm_d   = S_PLAY_OFF;
               end else begin
                  ph_cnt_d = ph_cnt_q + 6'd1;
               end
            end
         end
         S_USER: begin
`ifdef SIMON_TIMEOUT_EN
            if (tick) begin
               to_cnt_d = to_cnt_q + 9'd1;
               if (to_cnt_q == 9'd299) fsm_d = S_FAIL;
            end
`endif
            // A press landing on the timeout tick still counts.
            if (key_evt) begin
`ifdef SIMON_TIMEOUT_EN
               to_cnt_d = '0;
`endif
               if (key_code == mem_q[index_q[AW-1:0]]) begin
                  index_d = index_q + 5'd1;
                  if (index_q + 5'd1 == round_q)
                     fsm_d = (round_q == 5'(MAX_LEN)) ? S_WIN : S_ADD;
                  else
                     fsm_d = S_USER;
               end else begin
                  fsm_d = S_FAIL;
               end
            end
         end
         S_FAIL, S_WIN: begin
            if (start) fsm_d = S_IDLE;
         end
         default: fsm_d = S_IDLE;
      endcase

      // Every playback phase starts with a full tick period and zero ticks.
      if ((fsm_d == S_PLAY_ON || fsm_d == S_PLAY_OFF) && fsm_d != fsm_q) begin
         tick_cnt_d = '0;
         ph_cnt_d   = '0;
      end
`ifdef SIMON_TIMEOUT_EN
      if (fsm_d == S_USER && fsm_q != S_USER) to_cnt_d = '0;
`endif
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         fsm_q      <= S_IDLE;
         lfsr_q     <= SEED;
         tick_cnt_q <= '0;
         ph_cnt_q   <= '0;
         lvl_q      <= 3'd1;
         round_q    <= '0;
         index_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         key_s1_q   <= 4'hF;
         key_s2_q   <= 4'hF;
         key_prev_q <= 4'hF;
`ifdef SIMON_TIMEOUT_EN
         to_cnt_q   <= '0;
`endif
      end else begin
         fsm_q      <= fsm_d;
         lfsr_q     <= lfsr_d;
         tick_cnt_q <= tick_cnt_d;
         ph_cnt_q   <= ph_cnt_d;
         lvl_q      <= lvl_d;
         round_q    <= round_d;
         index_q    <= index_d;
         mem_q      <= mem_d;
         key_s1_q   <= key_s1_d;
         key_s2_q   <= key_s2_d;
         key_prev_q <= key_prev_d;
`ifdef SIMON_TIMEOUT_EN
         to_cnt_q   <= to_cnt_d;
`endif
      end
   end

   // Outputs decode from the registered FSM state only (plus the key echo).
   always_comb begin
      state = 2'b00;
      color = 4'b0000;
      fail  = 1'b0;
      win   = 1'b0;
      case (fsm_q)
         S_IDLE:            state = 2'b00;
         S_ADD, S_PLAY_OFF: state = 2'b01;
         S_PLAY_ON: begin
            state = 2'b01;
            color = 4'b0001 << mem_q[index_q[AW-1:0]];
         end
         S_USER: begin
            state = 2'b10;
            color = ~key_s2_q;
         end
         S_FAIL: begin
            state = 2'b11;
            color = 4'b1111;
            fail  = 1'b1;
         end
         S_WIN: begin
            state = 2'b11;
            win   = 1'b1;
         end
         default: state = 2'b00;
      endcase
   end

   assign round = round_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// -----------------------------------------------------------------------------
// tb_simon_sequencer
//   Scoreboard bench: stimulus pushes each expected output snapshot
//   (state/color/round/fail/win) with its expected run length in cycles; a
//   monitor pops one entry every time the DUT outputs change and checks both
//   the new snapshot and how long the previous one lasted.
//   Runs with TICK_CYCLES=4 and MAX_LEN=2.
// -----------------------------------------------------------------------------
module tb_simon_sequencer;

   localparam int          TICK = 4;
   localparam int          MAXL = 2;
   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [2:0] level = 3'd5;
   logic [3:0] key_n = 4'hF;
   logic [1:0] state;
   logic [3:0] color;
   logic [4:0] round;
   logic       fail, win;

   simon_sequencer #(.MAX_LEN(MAXL), .TICK_CYCLES(TICK), .SEED(SEED)) dut (
      .CLOCK_50(clk), .reset(reset), .start(start), .level(level), .key_n(key_n),
      .state(state), .color(color), .round(round), .fail(fail), .win(win)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] st;
      logic [3:0] col;
      logic [4:0] rnd;
      logic       f;
      logic       w;
   } snap_t;

   typedef struct packed {
      snap_t       s;
      logic [15:0] dur;   // expected cycles this snapshot lasts, 0 = don't care
   } ent_t;

   ent_t        q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] m_lfsr;
   logic [1:0]  bm [4];

   // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, steps every cycle.
   always @(posedge clk)
      m_lfsr <= reset ? SEED : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

   function automatic logic [3:0] oh(input logic [1:0] v);
      logic [3:0] one;
      one = 4'b0001;
      return one << v;
   endfunction

   task automatic push(input logic [1:0] st, input logic [3:0] col, input logic [4:0] rnd,
                       input logic f, input logic w, input int dur);
      q.push_back(ent_t'({st, col, rnd, f, w, 16'(dur)}));
   endtask

   // ADD, leading gap, then ON/OFF for each element, ending in USER.
   task automatic push_game(input int r, input int offc, input int onc);
      push(2'b01, 4'h0, 5'(r - 1), 1'b0, 1'b0, 1);
      push(2'b01, 4'h0, 5'(r), 1'b0, 1'b0, offc);
      for (int i = 0; i < r; i++) begin
         push(2'b01, oh(bm[i]), 5'(r), 1'b0, 1'b0, onc);
         push(2'b01, 4'h0, 5'(r), 1'b0, 1'b0, offc);
      end
      push(2'b10, 4'h0, 5'(r), 1'b0, 1'b0, 0);
   endtask

   task automatic wait_st(input logic [1:0] s, input int budget, input string nm);
      for (int i = 0; i < budget && state !== s; i++) @(negedge clk);
      n_tests++;
      if (state !== s) begin
         n_fail++;
         $display("FAIL %s: state=%b, wanted %b within %0d cycles", nm, state, s, budget);
      end
   endtask

   // Start request held for 'hold' cycles; ADD is entered on the last edge.
   task automatic start_game(input int hold, input int offc, input int onc);
      @(negedge clk);
      start = 1'b1;
      repeat (hold) @(posedge clk);
      #1 bm[0] = m_lfsr[1:0];
      push_game(1, offc, onc);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Correct final key of a round: echo for one cycle, then ADD next round.
   task automatic press_adv(input logic [1:0] k, input int r_next);
      @(negedge clk);
      key_n = ~oh(k);
      push(2'b10, oh(k), 5'(r_next - 1), 1'b0, 1'b0, 1);
      repeat (3) @(posedge clk);
      #1 bm[r_next - 1] = m_lfsr[1:0];
      push_game(r_next, 20, 40);
      @(negedge clk);
      key_n = 4'hF;
   endtask

   // Key pattern held 3 cycles; pushes are done by the caller.
   task automatic hold_keys(input logic [3:0] pat);
      @(negedge clk);
      key_n = pat;
      repeat (3) @(negedge clk);
      key_n = 4'hF;
   endtask

   // Monitor
   snap_t       cur, prev;
   ent_t        e;
   int          run_len = 0;
   logic [15:0] prev_dur = '0;
   bit          first = 1'b1;

   always @(negedge clk) begin
      cur = '{st: state, col: color, rnd: round, f: fail, w: win};
      if (first || cur !== prev) begin
         if (!first && prev_dur != 0) begin
            n_tests++;
            if (run_len != int'(prev_dur)) begin
               n_fail++;
               $display("FAIL duration: st=%b col=%b rnd=%0d lasted %0d cycles, wanted %0d",
                        prev.st, prev.col, prev.rnd, run_len, prev_dur);
            end
         end
         n_tests++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected: st=%b col=%b rnd=%0d f=%b w=%b with nothing expected",
                     cur.st, cur.col, cur.rnd, cur.f, cur.w);
            prev_dur = '0;
         end else begin
            e = q.pop_front();
            if (e.s !== cur) begin
               n_fail++;
               $display("FAIL snapshot: got st=%b col=%b rnd=%0d f=%b w=%b, wanted st=%b col=%b rnd=%0d f=%b w=%b",
                        cur.st, cur.col, cur.rnd, cur.f, cur.w,
                        e.s.st, e.s.col, e.s.rnd, e.s.f, e.s.w);
            end
            prev_dur = e.dur;
         end
         prev    = cur;
         run_len = 1;
         first   = 1'b0;
      end else begin
         run_len++;
      end
   end

   initial begin
      // Reset state
      push(2'b00, 4'h0, 5'd0, 1'b0, 1'b0, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset in the middle of PLAY_ON
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 bm[0] = m_lfsr[1:0];
      push(2'b01, 4'h0, 5'd0, 1'b0, 1'b0, 1);
      push(2'b01, 4'h0, 5'd1, 1'b0, 1'b0, 20);
      push(2'b01, oh(bm[0]), 5'd1, 1'b0, 1'b0, 0);
      push(2'b00, 4'h0, 5'd0, 1'b0, 1'b0, 0);
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Level 5 game: OFF 5 ticks (20 cycles), ON 10 ticks (40 cycles)
      level = 3'd5;
      start_game(1, 20, 40);
      wait_st(2'b10, 200, "user_round1");

      // Two keys at once: echoed but ignored
      push(2'b10, 4'b0011, 5'd1, 1'b0, 1'b0, 3);
      push(2'b10, 4'b0000, 5'd1, 1'b0, 1'b0, 0);
      hold_keys(4'b1100);
      repeat (4) @(negedge clk);

      // Correct key advances to round 2; mem[0] replayed unchanged
      press_adv(bm[0], 2);
      wait_st(2'b10, 400, "user_round2");

      // Round 2: first element, stays in USER
      push(2'b10, oh(bm[0]), 5'd2, 1'b0, 1'b0, 3);
      push(2'b10, 4'b0000, 5'd2, 1'b0, 1'b0, 0);
      hold_keys(~oh(bm[0]));
      repeat (4) @(negedge clk);

      // Second element completes MAX_LEN -> WIN
      push(2'b10, oh(bm[1]), 5'd2, 1'b0, 1'b0, 1);
      push(2'b11, 4'b0000, 5'd2, 1'b0, 1'b1, 0);
      hold_keys(~oh(bm[1]));
      wait_st(2'b11, 20, "win");
      repeat (3) @(negedge clk);

      // start held through WIN -> IDLE -> ADD
      push(2'b00, 4'h0, 5'd2, 1'b0, 1'b0, 1);
      start_game(2, 20, 40);
      wait_st(2'b10, 200, "user_after_win");

      // Wrong key -> FAIL
      push(2'b10, oh(bm[0] + 2'd1), 5'd1, 1'b0, 1'b0, 1);
      push(2'b11, 4'b1111, 5'd1, 1'b1, 1'b0, 0);
      hold_keys(~oh(bm[0] + 2'd1));
      wait_st(2'b11, 20, "fail");
      repeat (3) @(negedge clk);

      // Out-of-range level 7 behaves as level 1: OFF 25 ticks, ON 50 ticks
      level = 3'd7;
      push(2'b00, 4'h0, 5'd1, 1'b0, 1'b0, 1);
      start_game(2, 100, 200);
      wait_st(2'b10, 1000, "user_level1");

`ifdef SIMON_TIMEOUT_EN
      push(2'b11, 4'b1111, 5'd1, 1'b1, 1'b0, 0);
      wait_st(2'b11, 1300, "timeout");
`endif

      repeat (3) @(negedge clk);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected snapshots never seen, wanted 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
